vacc_sched: RTL and testbench
=============================

Name: vacc_sched

Overview:
- Run-time sequencer for the vector accumulator.
- Arms the accumulator on software command and forwards the first spectrum sync as its one-time sync.
- Issues a one-cycle trigger per integration, then watches the accumulator's drain write strobe and address to detect dump start and completion.
- Keeps a dump sequence counter, supports single-shot and continuous modes, and flags stuck integrations with a watchdog.
- Sits between the control register block and the accumulator.

Parameters:
- VECTOR_WIDTH, 11, log2 of channels per spectrum; must match the accumulator.
- ACCUMULATIONS, 8, spectra per integration; must match the accumulator.
- COUNT_WIDTH, 32, width of the dump sequence counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ce  in  1  clock enable; all state, counters and pulses advance only when ce=1
- arm  in  1  start request, level-sampled
- stop  in  1  stop request, level-sampled
- continuous  in  1  1: retrigger after each dump; 0: single shot
- sync_in  in  1  one-cycle pulse marking channel 0 of a spectrum
- vacc_we  in  1  accumulator output write strobe
- vacc_addr  in  VECTOR_WIDTH  accumulator output address
- vacc_sync  out  1  one-cycle sync pulse to the accumulator
- vacc_trig  out  1  one-cycle trigger pulse to the accumulator
- dump_start  out  1  pulse on first drained word
- dump_done  out  1  pulse on last drained word
- dump_count  out  COUNT_WIDTH  completed dumps since reset
- busy  out  1  high in any state other than IDLE
- timeout  out  1  sticky watchdog flag, cleared by the next accepted arm
- state_o  out  3  current state encoding, for status readback

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; synced flag=0; watchdog=0.
  - All outputs 0, including dump_count and timeout.
  - Reset is honoured in any state, including mid-drain. The accumulator is not reset by this block.
- States and encodings: IDLE=0, WAIT_SYNC=1, INTEGRATE=2, DRAIN=3. All transitions are qualified by ce.
- IDLE:
  - arm=1 and stop=0 -> WAIT_SYNC; timeout cleared.
  - arm and stop both 1: stop wins, remain in IDLE.
- WAIT_SYNC:
  - stop=1 -> IDLE.
  - Else on sync_in=1: drive vacc_trig=1 on the next cycle, and vacc_sync=1 on the same cycle if the synced flag is 0; set synced=1; -> INTEGRATE; watchdog=0.
  - The synced flag is cleared only by reset, so the accumulator receives exactly one sync per reset.
- INTEGRATE:
  - Watchdog increments each ce cycle.
  - On vacc_we rising -> DRAIN and pulse dump_start.
  - A vacc_we rise with vacc_addr != 0 still enters DRAIN.
  - If the watchdog reaches (ACCUMULATIONS+3)*2^VECTOR_WIDTH with no vacc_we: set timeout, -> IDLE.
  - stop is latched as pending and does not abort the integration.
- DRAIN:
  - Exit when vacc_we=1 and vacc_addr = 2^VECTOR_WIDTH-1 (last word), or when vacc_we falls (truncated drain).
  - On exit: pulse dump_done and increment dump_count (wraps modulo 2^COUNT_WIDTH).
  - Next state: WAIT_SYNC if continuous=1 and no stop is pending; otherwise IDLE.
  - Pending stop clears on entry to IDLE.
- Output timing:
  - vacc_trig, vacc_sync, dump_start and dump_done are registered.
  - Each pulse lasts exactly one ce cycle, one cycle after the causing input.
- Simultaneous events:
  - sync_in arriving while in INTEGRATE or DRAIN is ignored.
  - continuous changes take effect at the next DRAIN exit.
- Counter width: the watchdog is VECTOR_WIDTH+6 bits (sufficient for ACCUMULATIONS up to 60).

Test Plan (VECTOR_WIDTH=3, ACCUMULATIONS=2, behavioural accumulator model):
- Reset, arm=1, continuous=0, sync_in at cycle 10 -> vacc_sync and vacc_trig high at cycle 11 only; drain addr 0..7 -> dump_start on addr 0, dump_done on addr 7, dump_count=1, back in IDLE with busy=0.
- continuous=1, three integrations -> vacc_sync pulses once only, vacc_trig pulses three times, dump_count=3, state returns to WAIT_SYNC after each dump.
- stop asserted mid-INTEGRATE in continuous mode -> current dump completes (dump_count increments by 1), then IDLE with no further vacc_trig.
- Model never asserts vacc_we -> timeout=1 after 5*8=40 ce cycles in INTEGRATE, state IDLE; next arm clears timeout.
- rst_n low during DRAIN at addr 4 -> all outputs 0 immediately (async), dump_count=0, state IDLE.
- ce held low for 20 cycles during INTEGRATE -> watchdog and state frozen; pulse timing shifts by exactly 20 cycles.

Source files
------------

// File: rtl/vacc_sched.sv
// Run-time sequencer for the vector accumulator: arm/sync/trigger handshake,
// drain detection, dump sequence counting and a stuck-integration watchdog.
module vacc_sched #(
    parameter int VECTOR_WIDTH  = 11,
    parameter int ACCUMULATIONS = 8,
    parameter int COUNT_WIDTH   = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ce,
    input  logic                    arm,
    input  logic                    stop,
    input  logic                    continuous,
    input  logic                    sync_in,
    input  logic                    vacc_we,
    input  logic [VECTOR_WIDTH-1:0] vacc_addr,
    output logic                    vacc_sync,
    output logic                    vacc_trig,
    output logic                    dump_start,
    output logic                    dump_done,
    output logic [COUNT_WIDTH-1:0]  dump_count,
    output logic                    busy,
    output logic                    timeout,
    output logic [2:0]              state_o
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] WAIT_SYNC = 3'd1;
    localparam logic [2:0] INTEGRATE = 3'd2;
    localparam logic [2:0] DRAIN     = 3'd3;

    localparam int WD_W = VECTOR_WIDTH + 6;
    // An integration plus generous drain slack; anything longer is a hung accumulator.
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'((ACCUMULATIONS + 3) << VECTOR_WIDTH);
    localparam logic [VECTOR_WIDTH-1:0] LAST_ADDR = '1;

    logic [2:0]      state;
    logic            synced;
    logic            stop_pend;
    logic            we_d;
    logic [WD_W-1:0] wd;
    logic [WD_W-1:0] wd_inc;
    logic            we_rise;
    logic            drain_end;

    assign wd_inc    = wd + 1'b1;
    assign we_rise   = vacc_we & ~we_d;
    assign drain_end = (vacc_we && vacc_addr == LAST_ADDR) || (!vacc_we && we_d);
    assign busy      = (state != IDLE);
    assign state_o   = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            synced     <= 1'b0;
            stop_pend  <= 1'b0;
            we_d       <= 1'b0;
            wd         <= '0;
            vacc_sync  <= 1'b0;
            vacc_trig  <= 1'b0;
            dump_start <= 1'b0;
            dump_done  <= 1'b0;
            dump_count <= '0;
            timeout    <= 1'b0;
        end else if (ce) begin
            we_d       <= vacc_we;
            vacc_sync  <= 1'b0;
            vacc_trig  <= 1'b0;
            dump_start <= 1'b0;
            dump_done  <= 1'b0;
            case (state)
                IDLE: begin
                    stop_pend <= 1'b0;
                    if (arm && !stop) begin
                        state   <= WAIT_SYNC;
                        timeout <= 1'b0;
                    end
                end
                WAIT_SYNC: begin
                    if (stop) begin
                        state <= IDLE;
                    end else if (sync_in) begin
                        // The accumulator only ever sees the first sync after reset.
                        vacc_trig <= 1'b1;
                        vacc_sync <= ~synced;
                        synced    <= 1'b1;
                        wd        <= '0;
                        state     <= INTEGRATE;
                    end
                end
                INTEGRATE: begin
                    if (stop) stop_pend <= 1'b1;
                    wd <= wd_inc;
                    if (we_rise) begin
                        dump_start <= 1'b1;
                        state      <= DRAIN;
                    end else if (wd_inc == WD_LIMIT) begin
                        timeout   <= 1'b1;
                        stop_pend <= 1'b0;
                        state     <= IDLE;
                    end
                end
                DRAIN: begin
                    if (stop) stop_pend <= 1'b1;
                    if (drain_end) begin
                        dump_done  <= 1'b1;
                        dump_count <= dump_count + 1'b1;
                        if (continuous && !stop_pend && !stop) begin
                            state <= WAIT_SYNC;
                        end else begin
                            state     <= IDLE;
                            stop_pend <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vacc_sched.sv
// Bench for vacc_sched: table of dump scenarios plus watchdog, clock-enable
// freeze and mid-drain reset sequences; pulses are checked against a queue.
module tb_vacc_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ce = 1'b1;
    logic        arm = 1'b0;
    logic        stop = 1'b0;
    logic        continuous = 1'b0;
    logic        sync_in = 1'b0;
    logic        vacc_we = 1'b0;
    logic [2:0]  vacc_addr = 3'd0;
    logic        vacc_sync, vacc_trig, dump_start, dump_done, busy, timeout;
    logic [31:0] dump_count;
    logic [2:0]  state_o;

    vacc_sched #(.VECTOR_WIDTH(3), .ACCUMULATIONS(2), .COUNT_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .arm(arm), .stop(stop),
        .continuous(continuous), .sync_in(sync_in), .vacc_we(vacc_we),
        .vacc_addr(vacc_addr), .vacc_sync(vacc_sync), .vacc_trig(vacc_trig),
        .dump_start(dump_start), .dump_done(dump_done), .dump_count(dump_count),
        .busy(busy), .timeout(timeout), .state_o(state_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int tests = 0;
    int fails = 0;

    // kind: 0 vacc_sync, 1 vacc_trig, 2 dump_start, 3 dump_done
    typedef struct { int kind; int cyc; } ev_t;
    ev_t exp_q[$];

    typedef struct {
        bit cont;
        bit stop_mid;
        bit sync_mid;
        int nwords;
        int a0;
        int exp_state;
    } vec_t;
    vec_t vecs[8];

    int m_count  = 0;
    bit m_synced = 0;
    int m_state  = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int at);
        ev_t e;
        e.kind = kind;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    task automatic chk_ev(input int kind);
        ev_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL pulse: got unexpected kind %0d at cyc %0d, expected none", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc) begin
                fails++;
                $display("FAIL pulse: got kind %0d at cyc %0d, expected kind %0d at cyc %0d",
                         kind, cyc, e.kind, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (vacc_sync)  chk_ev(0);
            if (vacc_trig)  chk_ev(1);
            if (dump_start) chk_ev(2);
            if (dump_done)  chk_ev(3);
        end
    end

    task automatic do_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
        m_state = 1;
    endtask

    task automatic do_sync();
        sync_in = 1'b1;
        if (!m_synced) push(0, cyc + 1);
        push(1, cyc + 1);
        m_synced = 1;
        step();
        sync_in = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        int last;
        tag = $sformatf("vec%0d", idx);
        if (m_state == 0) do_arm();
        continuous = v.cont;
        step();
        step();
        do_sync();
        step();
        if (v.sync_mid) sync_in = 1'b1;
        step();
        sync_in = 1'b0;
        if (v.stop_mid) stop = 1'b1;
        step();
        stop = 1'b0;
        step();
        for (int i = 0; i < v.nwords; i++) begin
            vacc_we   = 1'b1;
            vacc_addr = 3'(v.a0 + i);
            if (i == 0) push(2, cyc + 1);
            if (v.a0 + i == 7) push(3, cyc + 1);
            step();
        end
        last = v.a0 + v.nwords - 1;
        vacc_we   = 1'b0;
        vacc_addr = 3'd0;
        if (last != 7) push(3, cyc + 1);
        step();
        step();
        m_count++;
        m_state = v.exp_state;
        check({tag, " state"}, int'(state_o), m_state);
        check({tag, " dump_count"}, int'(dump_count), m_count);
        check({tag, " busy"}, int'(busy), (m_state != 0) ? 1 : 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " vacc_sync"}, int'(vacc_sync), 0);
        check({tag, " vacc_trig"}, int'(vacc_trig), 0);
        check({tag, " dump_start"}, int'(dump_start), 0);
        check({tag, " dump_done"}, int'(dump_done), 0);
        check({tag, " dump_count"}, int'(dump_count), 0);
        check({tag, " busy"}, int'(busy), 0);
        check({tag, " timeout"}, int'(timeout), 0);
        check({tag, " state"}, int'(state_o), 0);
    endtask

    initial begin
        int n;
        //        cont stop sync nw a0 state
        vecs[0] = '{0, 0, 0, 8, 0, 0};  // single shot, full drain
        vecs[1] = '{1, 0, 0, 8, 0, 1};  // continuous x3
        vecs[2] = '{1, 0, 1, 8, 0, 1};  // sync during integrate ignored
        vecs[3] = '{1, 0, 0, 8, 0, 1};
        vecs[4] = '{1, 1, 0, 8, 0, 0};  // stop mid-integrate: dump completes, then idle
        vecs[5] = '{0, 0, 0, 4, 2, 0};  // truncated drain 2..5
        vecs[6] = '{1, 0, 0, 3, 5, 1};  // drain starting at nonzero addr
        vecs[7] = '{0, 0, 0, 8, 0, 0};

        repeat (3) step();
        check_all_zero("reset");
        rst_n = 1'b1;
        step();

        // arm and stop together: stop wins
        arm = 1'b1;
        stop = 1'b1;
        step();
        arm = 1'b0;
        stop = 1'b0;
        step();
        check("arm+stop state", int'(state_o), 0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // watchdog: no drain, expires after 40 INTEGRATE cycles
        if (m_state == 0) do_arm();
        step();
        n = cyc;
        do_sync();
        while (cyc < n + 40) step();
        check("wd pre state", int'(state_o), 2);
        check("wd pre timeout", int'(timeout), 0);
        step();
        check("wd timeout", int'(timeout), 1);
        check("wd state", int'(state_o), 0);
        do_arm();
        check("arm clears timeout", int'(timeout), 0);
        check("arm state", int'(state_o), 1);

        // ce low for 20 cycles shifts watchdog expiry by 20
        step();
        n = cyc;
        do_sync();
        step();
        step();
        ce = 1'b0;
        repeat (20) step();
        check("ce frozen state", int'(state_o), 2);
        ce = 1'b1;
        while (cyc < n + 60) step();
        check("ce wd pre state", int'(state_o), 2);
        check("ce wd pre timeout", int'(timeout), 0);
        step();
        check("ce wd timeout", int'(timeout), 1);
        check("ce wd state", int'(state_o), 0);
        m_state = 0;

        // async reset mid-drain at addr 4
        continuous = 1'b0;
        do_arm();
        step();
        do_sync();
        repeat (3) step();
        for (int i = 0; i <= 4; i++) begin
            vacc_we   = 1'b1;
            vacc_addr = 3'(i);
            if (i == 0) push(2, cyc + 1);
            if (i < 4) step();
        end
        check("pre-reset state", int'(state_o), 3);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async rst");
        vacc_we   = 1'b0;
        vacc_addr = 3'd0;
        step();
        step();
        rst_n = 1'b1;
        m_count  = 0;
        m_synced = 0;
        m_state  = 0;
        step();
        check("post-reset count", int'(dump_count), 0);
        check("post-reset state", int'(state_o), 0);

        // after reset the accumulator must get a fresh sync
        run_vec(vecs[0], 8);

        repeat (3) step();
        check("queue drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, expected completion");
        $fatal(1);
    end

endmodule
